// File: rtl/sap_control_sequencer.sv
// rtl/sap_control_sequencer.sv - six-state ring counter and opcode decoder for the 8-bit accumulator machine
module sap_control_sequencer (
  input  logic        clk,
  input  logic        clr_n,
  input  logic [3:0]  opcode,
  output logic [11:0] con,
  output logic        hlt,
  output logic [5:0]  t_state
);

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;

  localparam int CP = 11, EP = 10, LM = 9, CE = 8, LI = 7, EI = 6;
  localparam int LA = 5,  EA = 4,  SU = 3, EU = 2, LB = 1, LO = 0;

  logic        halted;
  logic        hlt_decode;
  logic [11:0] con_decode;

  assign hlt_decode = (t_state == T4) && (opcode == OP_HLT);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      t_state <= T1;
      halted  <= 1'b0;
    end else if (halted) begin
      t_state <= t_state;
    end else if (hlt_decode) begin
      // ring stays parked at T4 from here until the next reset
      halted  <= 1'b1;
    end else begin
      t_state <= {t_state[4:0], t_state[5]};
    end
  end

  always_comb begin
    con_decode = 12'h000;
    if (!halted) begin
      case (t_state)
        T1: begin
          con_decode[EP] = 1'b1;
          con_decode[LM] = 1'b1;
        end
        T2: con_decode[CP] = 1'b1;
        T3: begin
          con_decode[CE] = 1'b1;
          con_decode[LI] = 1'b1;
        end
        T4: begin
          if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
            con_decode[EI] = 1'b1;
            con_decode[LM] = 1'b1;
          end else if (opcode == OP_OUT) begin
            con_decode[EA] = 1'b1;
            con_decode[LO] = 1'b1;
          end
        end
        T5: begin
          if (opcode == OP_LDA) begin
            con_decode[CE] = 1'b1;
            con_decode[LA] = 1'b1;
          end else if (opcode == OP_ADD || opcode == OP_SUB) begin
            con_decode[CE] = 1'b1;
            con_decode[LB] = 1'b1;
          end
        end
        T6: begin
          // su rides with eu so the ALU carry-in completes the two's-complement subtract
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            con_decode[EU] = 1'b1;
            con_decode[LA] = 1'b1;
            con_decode[SU] = (opcode == OP_SUB);
          end
        end
        default: con_decode = 12'h000;
      endcase
    end
  end

  assign con = clr_n ? con_decode : 12'h000;
  assign hlt = clr_n & (halted | hlt_decode);

endmodule

// File: tb/tb_sap_control_sequencer.sv
// tb/tb_sap_control_sequencer.sv - directed self-checking bench for sap_control_sequencer
module tb_sap_control_sequencer;

  logic        clk;
  logic        clr_n;
  logic [3:0]  opcode;
  logic [11:0] con;
  logic        hlt;
  logic [5:0]  t_state;

  int total;
  int passed;

  logic [7:0] a_reg, b_reg, out_reg, ram_data, bus;
  int         violations;

  sap_control_sequencer dut (
    .clk     (clk),
    .clr_n   (clr_n),
    .opcode  (opcode),
    .con     (con),
    .hlt     (hlt),
    .t_state (t_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // minimal accumulator datapath hung off the control word
  always_comb begin
    bus = 8'h00;
    if (con[8])      bus = ram_data;
    else if (con[4]) bus = a_reg;
    else if (con[2]) bus = con[3] ? (a_reg + ~b_reg + 8'd1) : (a_reg + b_reg);
  end

  always @(posedge clk) begin
    if (con[5]) a_reg   <= bus;
    if (con[1]) b_reg   <= bus;
    if (con[0]) out_reg <= bus;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp)
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    else
      passed++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input string tag, input logic [3:0] op,
                           input logic [11:0] e4, input logic [11:0] e5, input logic [11:0] e6);
    opcode = op;
    check({tag, " T1 state"}, {10'd0, t_state}, 16'h0001);
    check({tag, " T1 con"}, {4'd0, con}, 16'h0600);
    step();
    check({tag, " T2 con"}, {4'd0, con}, 16'h0800);
    step();
    check({tag, " T3 con"}, {4'd0, con}, 16'h0180);
    step();
    check({tag, " T4 state"}, {10'd0, t_state}, 16'h0008);
    check({tag, " T4 con"}, {4'd0, con}, {4'd0, e4});
    step();
    check({tag, " T5 con"}, {4'd0, con}, {4'd0, e5});
    step();
    check({tag, " T6 con"}, {4'd0, con}, {4'd0, e6});
    step();
    check({tag, " wrap"}, {10'd0, t_state}, 16'h0001);
  endtask

  initial begin
    total = 0;
    passed = 0;
    violations = 0;
    clr_n = 1'b0;
    opcode = 4'h0;
    ram_data = 8'h00;
    a_reg = 8'h00;
    b_reg = 8'h00;
    out_reg = 8'h00;

    repeat (3) step();
    check("reset state", {10'd0, t_state}, 16'h0001);
    check("reset con", {4'd0, con}, 16'h0000);
    check("reset hlt", {15'd0, hlt}, 16'h0000);
    clr_n = 1'b1;
    #1;
    check("release T1 con", {4'd0, con}, 16'h0600);
    step();
    check("first edge state", {10'd0, t_state}, 16'h0002);
    check("first edge con", {4'd0, con}, 16'h0800);
    repeat (5) step();

    ram_data = 8'd7;
    run_instr("lda7", 4'b0000, 12'h240, 12'h120, 12'h000);
    check("lda A", {8'd0, a_reg}, 16'd7);
    ram_data = 8'd9;
    run_instr("add", 4'b0001, 12'h240, 12'h102, 12'h024);
    check("add A", {8'd0, a_reg}, 16'd16);
    run_instr("sub", 4'b0010, 12'h240, 12'h102, 12'h02C);
    check("sub A", {8'd0, a_reg}, 16'd7);
    ram_data = 8'd5;
    run_instr("lda5", 4'b0000, 12'h240, 12'h120, 12'h000);
    ram_data = 8'd9;
    run_instr("subwrap", 4'b0010, 12'h240, 12'h102, 12'h02C);
    check("sub wrap A", {8'd0, a_reg}, 16'h00FC);
    run_instr("out", 4'b1110, 12'h011, 12'h000, 12'h000);
    check("out reg", {8'd0, out_reg}, 16'h00FC);
    run_instr("nop", 4'b0111, 12'h000, 12'h000, 12'h000);

    opcode = 4'b1111;
    check("pre-hlt hlt", {15'd0, hlt}, 16'h0000);
    repeat (3) step();
    check("hlt T4 flag", {15'd0, hlt}, 16'h0001);
    check("hlt T4 con", {4'd0, con}, 16'h0000);
    repeat (10) step();
    opcode = 4'b0001;
    #1;
    check("halted state", {10'd0, t_state}, 16'h0008);
    check("halted con", {4'd0, con}, 16'h0000);
    check("halted hlt", {15'd0, hlt}, 16'h0001);
    #2 clr_n = 1'b0;
    #1;
    check("halt clear state", {10'd0, t_state}, 16'h0001);
    check("halt clear hlt", {15'd0, hlt}, 16'h0000);
    step();
    clr_n = 1'b1;
    #1;

    opcode = 4'b0001;
    repeat (4) step();
    check("mid T5 con", {4'd0, con}, 16'h0102);
    #2 clr_n = 1'b0;
    #1;
    check("mid reset con", {4'd0, con}, 16'h0000);
    check("mid reset state", {10'd0, t_state}, 16'h0001);
    step();
    clr_n = 1'b1;
    #1;

    for (int i = 0; i < 1000; i++) begin
      opcode = 4'($urandom_range(0, 14));
      for (int c = 0; c < 6; c++) begin
        if ($countones({con[10], con[8], con[6], con[4], con[2]}) > 1) violations++;
        if (c == 3 && ($urandom_range(0, 3) == 0)) begin
          opcode = 4'($urandom_range(0, 14));
          #1;
          if ($countones({con[10], con[8], con[6], con[4], con[2]}) > 1) violations++;
        end
        step();
      end
    end
    check("bus invariant", violations[15:0], 16'd0);
    check("sweep ring", {10'd0, t_state}, 16'h0001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
